// File: rtl/out_arbiter_pkg.sv
// Shared definitions for the seven-segment output arbiter.
// Slot/value widths and the arbiter FSM state encoding.
package out_pkg;

  localparam int SLOT_W = 3;
  localparam int NSLOT  = 8;
  localparam int VAL_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/out_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from i_last_grant+1.
// Zero latency, no state; o_any is low and o_grant is zero when nothing is requested.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last_grant,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_index,
  output logic          o_any
);

  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!o_any && i_req[(int'(i_last_grant) + k) % N]) begin
        o_any = 1'b1;
        o_grant[(int'(i_last_grant) + k) % N] = 1'b1;
        o_index = IW'((int'(i_last_grant) + k) % N);
      end
    end
  end

endmodule

// File: rtl/out_arbiter.sv
// Round-robin arbiter for the 8-slot display port: accept at t, strobe at t+1, next accept at t+2+GAP.
// Requesters wait while busy; OUT_ARB_SHADOW_EN suppresses strobes for writes identical to the slot's last value.
module out_arbiter
  import out_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GAP  = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [SLOT_W*NREQ-1:0] req_sel,
  input  logic [VAL_W*NREQ-1:0]  req_val1,
  input  logic [VAL_W*NREQ-1:0]  req_val2,
  output logic [NREQ-1:0]        req_ready,
  output logic [VAL_W-1:0]       outval1,
  output logic [VAL_W-1:0]       outval2,
  output logic [SLOT_W-1:0]      outsel,
  output logic                   outdisplay,
  output logic                   busy,
  output logic [15:0]            write_count
);

  localparam int IW = $clog2(NREQ);

  state_t            r_state;
  logic [IW-1:0]     r_last;
  logic [3:0]        r_gap;
  logic [VAL_W-1:0]  r_val1;
  logic [VAL_W-1:0]  r_val2;
  logic [SLOT_W-1:0] r_sel;
  logic [15:0]       r_cnt;

  logic [NREQ-1:0]   w_grant;
  logic [IW-1:0]     w_idx;
  logic              w_any;
  logic              w_take;
  logic              w_skip;
  logic [SLOT_W-1:0] w_sel;
  logic [VAL_W-1:0]  w_val1;
  logic [VAL_W-1:0]  w_val2;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .i_req        (req_valid),
    .i_last_grant (r_last),
    .o_grant      (w_grant),
    .o_index      (w_idx),
    .o_any        (w_any)
  );

  assign w_sel  = req_sel[SLOT_W*int'(w_idx) +: SLOT_W];
  assign w_val1 = req_val1[VAL_W*int'(w_idx) +: VAL_W];
  assign w_val2 = req_val2[VAL_W*int'(w_idx) +: VAL_W];

  // Gated by reset as well so a held request cannot see a ready pulse while in reset.
  assign w_take    = (r_state == IDLE) && w_any && !reset;
  assign req_ready = w_take ? w_grant : '0;

`ifdef OUT_ARB_SHADOW_EN
  logic [NSLOT-1:0] r_shv;
  logic [VAL_W-1:0] r_sh1 [NSLOT];
  logic [VAL_W-1:0] r_sh2 [NSLOT];

  assign w_skip = r_shv[w_sel] && (r_sh1[w_sel] == w_val1) && (r_sh2[w_sel] == w_val2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shv <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        r_sh1[i] <= '0;
        r_sh2[i] <= '0;
      end
    end else if (r_state == ISSUE) begin
      r_shv[r_sel] <= 1'b1;
      r_sh1[r_sel] <= r_val1;
      r_sh2[r_sel] <= r_val2;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= IW'(NREQ - 1);
      r_gap   <= '0;
      r_val1  <= '0;
      r_val2  <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_last <= w_idx;
            // A skipped write leaves the display registers untouched.
            if (!w_skip) begin
              r_sel   <= w_sel;
              r_val1  <= w_val1;
              r_val2  <= w_val2;
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_cnt <= r_cnt + 16'd1;
          if (GAP == 0) begin
            r_state <= IDLE;
          end else begin
            r_state <= HOLD;
            r_gap   <= 4'(GAP - 1);
          end
        end
        HOLD: begin
          if (r_gap == 4'd0) r_state <= IDLE;
          else               r_gap   <= r_gap - 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign outval1     = r_val1;
  assign outval2     = r_val2;
  assign outsel      = r_sel;
  assign outdisplay  = (r_state == ISSUE);
  assign busy        = (r_state != IDLE);
  assign write_count = r_cnt;

endmodule

// File: tb/tb_out_arbiter.sv
// Bench for out_arbiter: GAP=0 and GAP=3 instances against a cycle-timing reference model.
// Build with OUT_ARB_SHADOW_EN defined to exercise the duplicate-write suppression path.
module tb_out_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  v [2];
  logic [11:0] s [2];
  logic [63:0] a [2];
  logic [63:0] b [2];

  logic [3:0]  o_rdy  [2];
  logic [15:0] o_v1   [2];
  logic [15:0] o_v2   [2];
  logic [2:0]  o_sel  [2];
  logic        o_disp [2];
  logic        o_busy [2];
  logic [15:0] o_cnt  [2];

  out_arbiter #(.NREQ(4), .GAP(0)) dut0 (
    .clock(clk), .reset(rst), .req_valid(v[0]), .req_sel(s[0]), .req_val1(a[0]), .req_val2(b[0]),
    .req_ready(o_rdy[0]), .outval1(o_v1[0]), .outval2(o_v2[0]), .outsel(o_sel[0]),
    .outdisplay(o_disp[0]), .busy(o_busy[0]), .write_count(o_cnt[0])
  );

  out_arbiter #(.NREQ(4), .GAP(3)) dut3 (
    .clock(clk), .reset(rst), .req_valid(v[1]), .req_sel(s[1]), .req_val1(a[1]), .req_val2(b[1]),
    .req_ready(o_rdy[1]), .outval1(o_v1[1]), .outval2(o_v2[1]), .outsel(o_sel[1]),
    .outdisplay(o_disp[1]), .busy(o_busy[1]), .write_count(o_cnt[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic check(string tag, int m, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d] got=%0h exp=%0h", tag, m, got, exp);
    end
  endtask

  // Reference model: tracks when each instance is next free (accept at t -> free at t+2+GAP),
  // which cycle the pending strobe falls in, the last granted requester and the slot shadow.
  int          cyc = 0;
  int          nf [2];
  int          st_at [2];
  int          last [2];
  logic [15:0] mcnt [2], m1 [2], m2 [2], p1 [2], p2 [2];
  logic [2:0]  msel [2], psel [2];
  bit          shv [2][8];
  logic [15:0] sh1 [2][8], sh2 [2][8];
  logic [3:0]  seen_rdy [2];
  int          n_disp0 = 0;
  int          n_rdy0  = 0;

  always @(negedge clk) begin : model
    bit          eb, ed, skip;
    int          w;
    logic [3:0]  er;
    logic [2:0]  ws;
    logic [15:0] w1, w2;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        check("rst_disp", m, o_disp[m], 0);
        check("rst_busy", m, o_busy[m], 0);
        check("rst_rdy",  m, o_rdy[m], 0);
        check("rst_val1", m, o_v1[m], 0);
        check("rst_val2", m, o_v2[m], 0);
        check("rst_sel",  m, o_sel[m], 0);
        check("rst_cnt",  m, o_cnt[m], 0);
        nf[m] = 0; st_at[m] = -1; last[m] = 3;
        mcnt[m] = 0; m1[m] = 0; m2[m] = 0; msel[m] = 0;
        for (int j = 0; j < 8; j++) shv[m][j] = 0;
        seen_rdy[m] = 0;
      end else begin
        eb = (cyc < nf[m]);
        ed = (st_at[m] == cyc);
        er = 0; w = -1; skip = 0; ws = 0; w1 = 0; w2 = 0;
        if (!eb)
          for (int k = 1; k <= 4; k++)
            if (w < 0 && v[m][(last[m] + k) % 4]) w = (last[m] + k) % 4;
        if (w >= 0) begin
          er[w] = 1'b1;
          ws = s[m][3*w +: 3];
          w1 = a[m][16*w +: 16];
          w2 = b[m][16*w +: 16];
`ifdef OUT_ARB_SHADOW_EN
          skip = shv[m][ws] && (sh1[m][ws] == w1) && (sh2[m][ws] == w2);
`endif
        end
        check("busy", m, o_busy[m], eb);
        check("disp", m, o_disp[m], ed);
        check("ready", m, o_rdy[m], er);
        check("outsel", m, o_sel[m], msel[m]);
        check("outval1", m, o_v1[m], m1[m]);
        check("outval2", m, o_v2[m], m2[m]);
        check("count", m, o_cnt[m], mcnt[m]);
        if (ed) begin
          mcnt[m] = mcnt[m] + 16'd1;
          shv[m][psel[m]] = 1;
          sh1[m][psel[m]] = p1[m];
          sh2[m][psel[m]] = p2[m];
        end
        if (w >= 0) begin
          last[m] = w;
          if (skip) nf[m] = cyc + 1;
          else begin
            nf[m] = cyc + 2 + (m == 1 ? 3 : 0);
            st_at[m] = cyc + 1;
            psel[m] = ws; p1[m] = w1; p2[m] = w2;
            msel[m] = ws; m1[m] = w1; m2[m] = w2;
          end
        end
        seen_rdy[m] = o_rdy[m];
        if (m == 0) begin
          n_disp0 += int'(o_disp[0]);
          n_rdy0  += $countones(o_rdy[0]);
        end
      end
    end
    cyc++;
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(int m, int i, logic [2:0] sl, logic [15:0] x, logic [15:0] y);
    v[m][i] = 1'b1;
    s[m][3*i +: 3] = sl;
    a[m][16*i +: 16] = x;
    b[m][16*i +: 16] = y;
  endtask

  task automatic clear_all();
    v[0] = '0;
    v[1] = '0;
  endtask

  // Requesters allowed by mask raise with fresh data (p_raise %), hold until ready, may withdraw (p_drop %).
  task automatic run_random(int n, logic [3:0] mask, int p_raise, int p_drop);
    logic [2:0]  sl;
    logic [15:0] x, y;
    repeat (n) begin
      tick(1);
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < 4; i++) begin
          if (seen_rdy[m][i] || !v[m][i]) begin
            v[m][i] = 1'b0;
            if (mask[i] && int'($urandom_range(99)) < p_raise) begin
`ifdef OUT_ARB_SHADOW_EN
              sl = 3'($urandom_range(1)); x = 16'($urandom_range(1)); y = 16'($urandom_range(1));
`else
              sl = 3'($urandom_range(7)); x = 16'($urandom); y = 16'($urandom);
`endif
              set_req(m, i, sl, x, y);
            end
          end else if (int'($urandom_range(99)) < p_drop) begin
            v[m][i] = 1'b0;
          end
        end
    end
  endtask

  int d0, r0;

  initial begin
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      v[m] = '0; s[m] = '0; a[m] = '0; b[m] = '0;
    end
    tick(3);
    rst = 1'b0;

    // Single write from requester 0.
    tick(1);
    set_req(0, 0, 3'd5, 16'h1234, 16'hABCD);
    @(negedge clk);
    check("t1_ready", 0, o_rdy[0], 4'b0001);
    tick(1);
    v[0][0] = 1'b0;
    @(negedge clk);
    check("t1_disp", 0, o_disp[0], 1);
    check("t1_sel", 0, o_sel[0], 5);
    check("t1_val1", 0, o_v1[0], 16'h1234);
    check("t1_val2", 0, o_v2[0], 16'hABCD);
    tick(1);
    @(negedge clk);
    check("t1_count", 0, o_cnt[0], 1);
    check("t1_disp_off", 0, o_disp[0], 0);
    tick(1);

    // All requesters continuously valid, then only requester 1.
    run_random(12, 4'hF, 100, 0);
    clear_all();
    tick(6);
    run_random(30, 4'b0010, 100, 0);
    clear_all();
    tick(6);

    // Requester 2 withdraws while the GAP=3 instance is busy.
    set_req(1, 0, 3'd3, 16'h0101, 16'h0202);
    tick(1);
    v[1][0] = 1'b0;
    set_req(1, 2, 3'd4, 16'h0303, 16'h0404);
    @(negedge clk);
    check("wd_rdy_issue", 1, o_rdy[1], 0);
    check("wd_busy", 1, o_busy[1], 1);
    tick(1);
    v[1][2] = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("wd_rdy", 1, o_rdy[1], 0);
      check("wd_disp", 1, o_disp[1], 0);
    end
    tick(2);

    // Reset during ISSUE discards the accepted write.
    set_req(0, 3, 3'd1, 16'h5555, 16'h6666);
    tick(1);
    v[0][3] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rs_disp", 0, o_disp[0], 0);
    tick(1);
    rst = 1'b0;
    set_req(0, 0, 3'd4, 16'h0A0A, 16'h0B0B);
    set_req(0, 1, 3'd4, 16'h0C0C, 16'h0D0D);
    @(negedge clk);
    check("rs_first", 0, o_rdy[0], 4'b0001);
    check("rs_val1", 0, o_v1[0], 0);
    tick(1);
    v[0][0] = 1'b0;
    @(negedge clk);
    check("rs_disp2", 0, o_disp[0], 1);
    check("rs_val1b", 0, o_v1[0], 16'h0A0A);
    tick(2);
    clear_all();
    tick(4);

`ifdef OUT_ARB_SHADOW_EN
    // Identical write to slot 2 twice: two ready pulses, one strobe; new value strobes again.
    d0 = n_disp0; r0 = n_rdy0;
    set_req(0, 0, 3'd2, 16'h0001, 16'h0002);
    tick(1);
    v[0][0] = 1'b0;
    tick(2);
    set_req(0, 1, 3'd2, 16'h0001, 16'h0002);
    tick(1);
    v[0][1] = 1'b0;
    tick(3);
    check("sh_strobes", 0, n_disp0 - d0, 1);
    check("sh_ready", 0, n_rdy0 - r0, 2);
    d0 = n_disp0;
    set_req(0, 2, 3'd2, 16'h0003, 16'h0002);
    tick(1);
    v[0][2] = 1'b0;
    tick(3);
    check("sh_new", 0, n_disp0 - d0, 1);
`endif

    // Mixed random traffic with withdrawals.
    run_random(400, 4'hF, 30, 10);
    clear_all();
    tick(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
